uart_packet_tx: RTL and testbench
=================================

UART_PACKET_TX -- requirements
Module: uart_packet_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit; legal range 2 or more.
REQ-002 Parameter FRAME_BITS, default 12: data bits per UART frame; legal when at least 8 and at least ADDR_BITS+2.
REQ-003 Parameter ADDR_BITS, default 9: target address width.
REQ-004 Parameter PAYLOAD_BYTES, default 4: payload bytes per packet; legal range 1..16.
REQ-005 Parameter CHECKSUM_EN, default 1: when 1, a checksum frame is appended after the payload.
REQ-006 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-007 Port clk, input, 1 bit: clock, rising edge.
REQ-008 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-009 Port in_valid, input, 1 bit: a packet request is present.
REQ-010 Port in_ready, output, 1 bit: block can accept a packet; high exactly while the FSM is in IDLE or DONE.
REQ-011 Port in_mem, input, 1 bit: target memory select.
REQ-012 Port in_addr, input, ADDR_BITS bits: target address.
REQ-013 Port in_data, input, 8*PAYLOAD_BYTES bits: payload.
REQ-014 Port tx, output, 1 bit: UART line; idle level is 1.
REQ-015 Port busy, output, 1 bit: packet in flight; high in START, DATA and STOP.
REQ-016 Port done, output, 1 bit: one-cycle pulse when a packet completes.

Function
REQ-017 Acceptance: a packet is accepted on a rising edge where in_valid and in_ready are both 1. in_mem, in_addr and in_data are captured into internal registers on that edge. Later input changes have no effect until the next acceptance.
REQ-018 Packet content: N_FRAMES = 1 + PAYLOAD_BYTES + CHECKSUM_EN frames, sent in order:
  - Header frame = {1'b1, in_mem, in_addr}, zero-extended to FRAME_BITS.
  - Payload frames: byte i = in_data[8i+7:8i], for i = 0 .. PAYLOAD_BYTES-1, each zero-extended to FRAME_BITS.
  - Checksum frame (only when CHECKSUM_EN=1): sum of all payload bytes modulo 256, zero-extended; carries beyond bit 7 are discarded.
REQ-019 Frame format, in line order: one start bit (0), then FRAME_BITS data bits LSB first, then STOP_BITS stop bits (1). Each bit holds tx for exactly CLKS_PER_BIT cycles.
REQ-020 FSM states and transitions:
  - IDLE: goes to START on acceptance.
  - START: goes to DATA after CLKS_PER_BIT cycles.
  - DATA: goes to STOP after FRAME_BITS bit periods.
  - STOP: after STOP_BITS bit periods, goes to START if more frames remain, otherwise to DONE.
  - DONE: goes to START if a new acceptance occurs in this cycle, otherwise to IDLE.
REQ-021 Latency: tx falls for the header start bit on the first edge after acceptance. Frames follow back-to-back with no idle cycles between them.
REQ-022 Packet duration: the packet occupies exactly N_FRAMES*(1+FRAME_BITS+STOP_BITS)*CLKS_PER_BIT cycles. done is high in the following cycle, with tx=1.
REQ-023 Back-to-back packets: a packet accepted while in DONE starts its start bit on the next edge. The minimum inter-packet idle time is therefore exactly 1 cycle.
REQ-024 While busy, in_ready=0 and in_valid is ignored; no request is queued or dropped silently, because the source must hold in_valid.
REQ-025 Counters: the baud counter counts 0..CLKS_PER_BIT-1, the bit index counts 0..FRAME_BITS-1, and the frame index counts 0..N_FRAMES-1. Each counter wraps to 0 at its terminal count, with no overflow at maximum parameter values.
REQ-026 tx is driven from a register (glitch-free). done and busy are decoded from registered state only.

Reset
REQ-027 While reset is high, independent of clk:
  - state=IDLE;
  - all counters and capture registers are 0;
  - tx=1, busy=0, done=0, in_ready=1.
REQ-028 Reset asserted mid-packet aborts the packet immediately: tx returns to 1 with no partial stop bit, and no done pulse is issued.
REQ-029 After reset deasserts, the block is ready to accept on the first rising edge.

Verification (CLKS_PER_BIT=4, FRAME_BITS=12, ADDR_BITS=9, PAYLOAD_BYTES=4, CHECKSUM_EN=1, STOP_BITS=1; 56 cycles per frame)
REQ-030 Basic packet: accept in_mem=1, in_addr=0x155, in_data=0x12345678 -> frames 0x755, 0x078, 0x056, 0x034, 0x012, 0x014; busy high for 336 cycles; done pulses exactly once in cycle 337.
REQ-031 Checksum wrap: in_data=0xFFFFFFFF -> checksum frame 0x0FC. Same stimulus with CHECKSUM_EN=0 -> 5 frames, 280 busy cycles, no checksum frame.
REQ-032 Back-to-back: in_valid held high with two packets queued by the source -> second header start bit begins exactly 1 cycle after the first packet's last stop bit; no extra done pulses.
REQ-033 Input isolation: change in_data and pulse in_valid while busy -> transmitted frames are unchanged and in_ready stays 0.
REQ-034 Reset mid-packet: assert reset during the third frame's DATA state -> tx=1 and busy=0 in the same cycle, no done pulse; a new packet sent after reset is bit-exact.
REQ-035 Framing check: a line-side UART model samples every bit at mid-period -> no framing errors; start bits are 0 and stop bits are 1 in all frames; also run with STOP_BITS=2 -> 60 cycles per frame.

Source files
------------

// File: rtl/uart_packet_tx.sv
// Packet-framing UART transmitter: sends a header frame, the payload bytes and an optional
// checksum frame as back-to-back UART frames on a registered tx line.
module uart_packet_tx #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int FRAME_BITS    = 12,
    parameter int ADDR_BITS     = 9,
    parameter int PAYLOAD_BYTES = 4,
    parameter int CHECKSUM_EN   = 1,
    parameter int STOP_BITS     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mem,
    input  logic [ADDR_BITS-1:0]         in_addr,
    input  logic [8*PAYLOAD_BYTES-1:0]   in_data,
    output logic                         tx,
    output logic                         busy,
    output logic                         done
);
    localparam int N_FRAMES = 1 + PAYLOAD_BYTES + CHECKSUM_EN;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_W    = $clog2(FRAME_BITS);
    localparam int FIDX_W   = $clog2(N_FRAMES);
    localparam int DATA_W   = 8 * PAYLOAD_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [FIDX_W-1:0]     frame_q, frame_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  mem_q, mem_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  tx_q, tx_d;
    logic                  accept_s;
    logic                  baud_end_s;

    function automatic logic [7:0] checksum(input logic [DATA_W-1:0] data);
        logic [7:0] sum;
        sum = 8'd0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            sum = sum + data[8*i +: 8];
        end
        return sum;
    endfunction

    // Frame 0 is the header, frames 1..PAYLOAD_BYTES the payload, anything beyond the checksum.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [FIDX_W-1:0]    idx,
        input logic                 mem,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_W-1:0]    data
    );
        logic [FRAME_BITS-1:0] w;
        if (idx == {FIDX_W{1'b0}}) begin
            w = FRAME_BITS'({1'b1, mem, addr});
        end else if (int'(idx) > PAYLOAD_BYTES) begin
            w = FRAME_BITS'(checksum(data));
        end else begin
            w = FRAME_BITS'(8'(data >> (8 * (int'(idx) - 1))));
        end
        return w;
    endfunction

    // Handshake and baud-period terminal count.
    always_comb begin
        accept_s   = in_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        baud_end_s = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    end

    // Next-state logic; tx_d always carries the level of the bit the FSM is entering.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        shift_d = shift_q;
        mem_d   = mem_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = ST_START;
                    baud_d  = {CNT_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    frame_d = {FIDX_W{1'b0}};
                    mem_d   = in_mem;
                    addr_d  = in_addr;
                    data_d  = in_data;
                    shift_d = frame_word({FIDX_W{1'b0}}, in_mem, in_addr, in_data);
                    tx_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_d = ST_DATA;
                    baud_d  = {CNT_W{1'b0}};
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[FRAME_BITS-1:1]};
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d = {CNT_W{1'b0}};
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d = ST_STOP;
                        bit_d   = {BIT_W{1'b0}};
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[FRAME_BITS-1:1]};
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_d = {CNT_W{1'b0}};
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = {BIT_W{1'b0}};
                        if (frame_q == FIDX_W'(N_FRAMES - 1)) begin
                            state_d = ST_DONE;
                            frame_d = {FIDX_W{1'b0}};
                            tx_d    = 1'b1;
                        end else begin
                            state_d = ST_START;
                            frame_d = frame_q + FIDX_W'(1);
                            shift_d = frame_word(frame_q + FIDX_W'(1), mem_q, addr_q, data_q);
                            tx_d    = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, counters, capture registers and the tx line register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= {CNT_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            frame_q <= {FIDX_W{1'b0}};
            shift_q <= {FRAME_BITS{1'b0}};
            mem_q   <= 1'b0;
            addr_q  <= {ADDR_BITS{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            shift_q <= shift_d;
            mem_q   <= mem_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign done     = (state_q == ST_DONE);
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: three instances (default, no checksum, two stop bits)
// decoded by a mid-bit line sampler with hand-computed frame values.
module tb_uart_packet_tx;
    localparam int CPB = 4;
    localparam int FB  = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_mem = 1'b0;
    logic [8:0]  in_addr = 9'd0;
    logic [31:0] in_data = 32'd0;
    logic [2:0]  vld = 3'b000;
    logic [2:0]  rdy, txv, bsy, dn;
    logic [11:0] exp_f [6];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_packet_tx #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .ADDR_BITS(9), .PAYLOAD_BYTES(4),
                     .CHECKSUM_EN(1), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]), .in_mem(in_mem),
        .in_addr(in_addr), .in_data(in_data), .tx(txv[0]), .busy(bsy[0]), .done(dn[0]));

    uart_packet_tx #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .ADDR_BITS(9), .PAYLOAD_BYTES(4),
                     .CHECKSUM_EN(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]), .in_mem(in_mem),
        .in_addr(in_addr), .in_data(in_data), .tx(txv[1]), .busy(bsy[1]), .done(dn[1]));

    uart_packet_tx #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .ADDR_BITS(9), .PAYLOAD_BYTES(4),
                     .CHECKSUM_EN(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]), .in_mem(in_mem),
        .in_addr(in_addr), .in_data(in_data), .tx(txv[2]), .busy(bsy[2]), .done(dn[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present a packet and hold in_valid for exactly one rising edge.
    task automatic send(input int d, input logic m, input logic [8:0] a, input logic [31:0] dat);
        in_mem  = m;
        in_addr = a;
        in_data = dat;
        vld[d]  = 1'b1;
        @(posedge clk);
        #1 vld[d] = 1'b0;
    endtask

    // Called right after the accepting edge; samples each bit at its middle, strictly on schedule.
    task automatic rx_packet(input int d, input int nfr, input int stops, input string tag);
        int bcnt = 0;
        int dcnt = 0;
        int ferr = 0;
        logic [11:0] fr;
        for (int f = 0; f < nfr; f++) begin
            fr = 12'h000;
            for (int b = 0; b < 1 + FB + stops; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    if (bsy[d] === 1'b1) bcnt++;
                    if (dn[d] !== 1'b0) dcnt++;
                    if (c == CPB / 2 - 1) begin
                        if (b == 0) begin
                            if (txv[d] !== 1'b0) ferr++;
                        end else if (b <= FB) begin
                            fr[b-1] = txv[d];
                        end else begin
                            if (txv[d] !== 1'b1) ferr++;
                        end
                    end
                end
            end
            check($sformatf("%s frame%0d", tag, f), {20'd0, fr}, {20'd0, exp_f[f]});
        end
        check({tag, " framing"}, ferr, 0);
        check({tag, " busy cycles"}, bcnt, nfr * (1 + FB + stops) * CPB);
        check({tag, " early done"}, dcnt, 0);
    endtask

    // The cycle after the last stop bit: done, tx idle, ready.
    task automatic post_check(input int d, input string tag);
        @(negedge clk);
        check({tag, " done pulse"}, dn[d], 1);
        check({tag, " tx after"}, txv[d], 1);
        check({tag, " busy after"}, bsy[d], 0);
        check({tag, " ready after"}, rdy[d], 1);
        @(negedge clk);
        check({tag, " done single"}, dn[d], 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst tx", txv, 3'b111);
        check("rst busy", bsy, 3'b000);
        check("rst done", dn, 3'b000);
        check("rst ready", rdy, 3'b111);
        reset = 1'b0;
        check("ready at release", rdy[0], 1);

        // Basic packet.
        exp_f = '{12'h755, 12'h078, 12'h056, 12'h034, 12'h012, 12'h014};
        send(0, 1'b1, 9'h155, 32'h12345678);
        rx_packet(0, 6, 1, "basic");
        post_check(0, "basic");

        // Checksum wrap on the default instance.
        exp_f = '{12'h4AA, 12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, 12'h0FC};
        send(0, 1'b0, 9'h0AA, 32'hFFFFFFFF);
        rx_packet(0, 6, 1, "wrap");
        post_check(0, "wrap");

        // Back-to-back: in_valid held, source swaps to the second packet after acceptance.
        in_mem = 1'b1; in_addr = 9'h155; in_data = 32'h12345678; vld[0] = 1'b1;
        @(posedge clk);
        #1 in_mem = 1'b0; in_addr = 9'h001; in_data = 32'h01020304;
        exp_f = '{12'h755, 12'h078, 12'h056, 12'h034, 12'h012, 12'h014};
        rx_packet(0, 6, 1, "b2b first");
        @(negedge clk);
        check("b2b done", dn[0], 1);
        check("b2b gap tx", txv[0], 1);
        @(posedge clk);
        #1 vld[0] = 1'b0;
        exp_f = '{12'h401, 12'h004, 12'h003, 12'h002, 12'h001, 12'h00A};
        rx_packet(0, 6, 1, "b2b second");
        post_check(0, "b2b second");

        // Input isolation: new data and an in_valid pulse mid-packet must be ignored.
        exp_f = '{12'h6F0, 12'h0EF, 12'h0BE, 12'h0AD, 12'h0DE, 12'h038};
        send(0, 1'b1, 9'h0F0, 32'hDEADBEEF);
        fork
            rx_packet(0, 6, 1, "iso");
            begin
                repeat (100) @(negedge clk);
                in_data = 32'h00000000; in_mem = 1'b0; in_addr = 9'h000; vld[0] = 1'b1;
                check("iso ready", rdy[0], 0);
                @(negedge clk);
                check("iso ready held", rdy[0], 0);
                vld[0] = 1'b0;
            end
        join
        post_check(0, "iso");

        // Reset during the third frame's DATA state.
        send(0, 1'b1, 9'h155, 32'h12345678);
        repeat (2 * 56 + 10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid rst tx", txv[0], 1);
        check("mid rst busy", bsy[0], 0);
        check("mid rst done", dn[0], 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post rst no done", dn[0], 0);
        check("post rst ready", rdy[0], 1);
        exp_f = '{12'h7FF, 12'h011, 12'h022, 12'h033, 12'h044, 12'h0AA};
        send(0, 1'b1, 9'h1FF, 32'h44332211);
        rx_packet(0, 6, 1, "after rst");
        post_check(0, "after rst");

        // No checksum frame.
        exp_f = '{12'h4AA, 12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, 12'h000};
        send(1, 1'b0, 9'h0AA, 32'hFFFFFFFF);
        rx_packet(1, 5, 1, "nochk");
        post_check(1, "nochk");

        // Two stop bits: 60 cycles per frame.
        exp_f = '{12'h755, 12'h078, 12'h056, 12'h034, 12'h012, 12'h014};
        send(2, 1'b1, 9'h155, 32'h12345678);
        rx_packet(2, 6, 2, "stop2");
        post_check(2, "stop2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
